// File: rtl/servo_pkg.sv
// Shared definitions for the multi-channel servo PWM sweep block:
// direction encodings, default timing constants and a small width helper.
package servo_pkg;

  // Per-channel direction code driven by the tracker/controller logic.
  // Both 00 and 11 mean "hold"; only 01 and 10 move the width.
  typedef enum logic [1:0] {
    DIR_HOLD     = 2'b00,
    DIR_INC      = 2'b01,
    DIR_DEC      = 2'b10,
    DIR_HOLD_ALT = 2'b11
  } dir_e;

  // Default timing: 1 us tick from a 100 MHz clock, 20 ms servo frame,
  // and the usual 0.5 ms / 1.5 ms / 2.5 ms hobby-servo pulse widths.
  localparam int DEF_N_CH      = 2;
  localparam int DEF_PW_W      = 16;
  localparam int DEF_CLK_DIV   = 100;
  localparam int DEF_FRAME_US  = 20000;
  localparam int DEF_MIN_PW    = 500;
  localparam int DEF_MAX_PW    = 2500;
  localparam int DEF_CENTER_PW = 1500;
  localparam int DEF_STEP      = 10;

  // Bit width needed to hold 0..n-1, never less than one bit so that
  // single-channel or divide-by-one builds still get a legal vector.
  function automatic int clog2_min1(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/servo_channel.sv
// One servo channel: shadow and active pulse-width registers, the per-frame
// step with saturation, the direct-load path and the registered PWM compare.
// The shadow register absorbs every change; the active register only copies
// it at a frame boundary, so the width driving the pin never moves mid-pulse.
module servo_channel
  import servo_pkg::*;
#(
  parameter int PW_W      = DEF_PW_W,
  parameter int MIN_PW    = DEF_MIN_PW,
  parameter int MAX_PW    = DEF_MAX_PW,
  parameter int CENTER_PW = DEF_CENTER_PW,
  parameter int STEP      = DEF_STEP
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            en,
  input  logic            frame_boundary,
  input  logic [PW_W-1:0] frame_cnt,
  input  logic [1:0]      dir,
  input  logic            load,
  input  logic [PW_W-1:0] load_val,
  output logic            servo,
  output logic [PW_W-1:0] active_pw,
  output logic            at_min,
  output logic            at_max
);

  // Constants in the operating width and in the one-bit-wider width used
  // for step arithmetic, so an increment or decrement can never wrap.
  localparam logic [PW_W-1:0] MIN_L    = PW_W'(MIN_PW);
  localparam logic [PW_W-1:0] MAX_L    = PW_W'(MAX_PW);
  localparam logic [PW_W-1:0] CENTER_L = PW_W'(CENTER_PW);
  localparam logic [PW_W:0]   MIN_X    = (PW_W+1)'(MIN_PW);
  localparam logic [PW_W:0]   MAX_X    = (PW_W+1)'(MAX_PW);
  localparam logic [PW_W:0]   STEP_X   = (PW_W+1)'(STEP);

  logic [PW_W-1:0] shadow_q, shadow_d;
  logic [PW_W-1:0] active_q, active_d;
  logic            servo_q,  servo_d;

  logic [PW_W:0]   shadow_x;
  logic [PW_W:0]   inc_x;
  logic [PW_W:0]   dec_x;
  logic [PW_W-1:0] stepped;
  logic [PW_W-1:0] load_clamped;

  // Candidate next shadow width: the DIR step, saturated at MIN/MAX.
  always_comb begin
    shadow_x = {1'b0, shadow_q};
    inc_x    = shadow_x + STEP_X;
    dec_x    = shadow_x - STEP_X;
    stepped  = shadow_q;
    case (dir_e'(dir))
      DIR_INC: begin
        stepped = (inc_x > MAX_X) ? MAX_L : inc_x[PW_W-1:0];
      end
      DIR_DEC: begin
        // A set top bit means the subtraction went below zero.
        stepped = (dec_x[PW_W] || (dec_x < MIN_X)) ? MIN_L : dec_x[PW_W-1:0];
      end
      default: begin
        stepped = shadow_q;
      end
    endcase
  end

  // Requested direct-load width, clamped into the legal servo range.
  always_comb begin
    load_clamped = load_val;
    if (load_val < MIN_L) begin
      load_clamped = MIN_L;
    end else if (load_val > MAX_L) begin
      load_clamped = MAX_L;
    end
  end

  // Next-state selection: boundary promotes shadow to active and steps the
  // shadow; a load on the same cycle overrides the step for this channel.
  always_comb begin
    shadow_d = shadow_q;
    active_d = active_q;
    if (frame_boundary) begin
      active_d = shadow_q;
      shadow_d = stepped;
    end
    if (load) begin
      shadow_d = load_clamped;
    end
    // Registered compare: output is high while the tick count is below
    // the active width, so high time equals the width in ticks.
    servo_d = en && (frame_cnt < active_q);
  end

  // Channel state registers with asynchronous reset to the centre width.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      shadow_q <= CENTER_L;
      active_q <= CENTER_L;
      servo_q  <= 1'b0;
    end else begin
      shadow_q <= shadow_d;
      active_q <= active_d;
      servo_q  <= servo_d;
    end
  end

  assign servo     = servo_q;
  assign active_pw = active_q;
  assign at_min    = (active_q == MIN_L);
  assign at_max    = (active_q == MAX_L);

endmodule

// File: rtl/servo_pwm_sweep.sv
// Multi-channel hobby-servo PWM generator. A shared prescaler produces a
// 1-tick strobe, a shared frame counter walks 0..FRAME_US-1 on those ticks,
// and each channel compares the frame count against its own active width.
// Widths ramp once per frame according to DIR, or are loaded directly.
module servo_pwm_sweep
  import servo_pkg::*;
#(
  parameter int N_CH      = DEF_N_CH,
  parameter int PW_W      = DEF_PW_W,
  parameter int CLK_DIV   = DEF_CLK_DIV,
  parameter int FRAME_US  = DEF_FRAME_US,
  parameter int MIN_PW    = DEF_MIN_PW,
  parameter int MAX_PW    = DEF_MAX_PW,
  parameter int CENTER_PW = DEF_CENTER_PW,
  parameter int STEP      = DEF_STEP
) (
  input  logic                        CLK,
  input  logic                        RST_N,
  input  logic                        EN,
  input  logic [2*N_CH-1:0]           DIR,
  input  logic                        LOAD,
  input  logic [clog2_min1(N_CH)-1:0] LOAD_CH,
  input  logic [PW_W-1:0]             LOAD_VAL,
  output logic [N_CH-1:0]             SERVO,
  output logic [PW_W*N_CH-1:0]        PULSE_WIDTH,
  output logic [N_CH-1:0]             AT_MIN,
  output logic [N_CH-1:0]             AT_MAX,
  output logic                        FRAME_START
);

  localparam int              CH_W       = clog2_min1(N_CH);
  localparam int              PRESC_W    = clog2_min1(CLK_DIV);
  localparam logic [PRESC_W-1:0] PRESC_LAST = PRESC_W'(CLK_DIV - 1);
  localparam logic [PW_W-1:0] FRAME_LAST = PW_W'(FRAME_US - 1);

  // Reject parameter sets where the width ordering or counter range breaks.
  if (!((N_CH >= 1) && (CLK_DIV >= 1) &&
        (MIN_PW <= CENTER_PW) && (CENTER_PW <= MAX_PW) &&
        (MAX_PW < FRAME_US) &&
        (longint'(FRAME_US) < (longint'(1) << PW_W)))) begin : g_bad_params
    $error("servo_pwm_sweep: need MIN_PW<=CENTER_PW<=MAX_PW<FRAME_US<2**PW_W");
  end

  logic [PRESC_W-1:0] presc_q,       presc_d;
  logic [PW_W-1:0]    frame_cnt_q,   frame_cnt_d;
  logic               frame_start_q, frame_start_d;
  logic               tick;
  logic               boundary;
  logic [N_CH-1:0]    load_hit;

  // Shared timebase: prescaler tick, frame counter and boundary detect.
  // With EN low both counters are parked at zero so re-enabling starts
  // a fresh frame, and no boundary (hence no width step) can occur.
  always_comb begin
    presc_d     = presc_q;
    frame_cnt_d = frame_cnt_q;
    tick        = 1'b0;
    boundary    = 1'b0;
    if (!EN) begin
      presc_d     = '0;
      frame_cnt_d = '0;
    end else begin
      if (presc_q == PRESC_LAST) begin
        presc_d = '0;
        tick    = 1'b1;
      end else begin
        presc_d = presc_q + 1'b1;
      end
      if (tick) begin
        if (frame_cnt_q == FRAME_LAST) begin
          frame_cnt_d = '0;
          boundary    = 1'b1;
        end else begin
          frame_cnt_d = frame_cnt_q + 1'b1;
        end
      end
    end
    frame_start_d = boundary;
  end

  // Timebase registers; FRAME_START lands with the counter's return to 0.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      presc_q       <= '0;
      frame_cnt_q   <= '0;
      frame_start_q <= 1'b0;
    end else begin
      presc_q       <= presc_d;
      frame_cnt_q   <= frame_cnt_d;
      frame_start_q <= frame_start_d;
    end
  end

  assign FRAME_START = frame_start_q;

  // One channel per servo; a load selector that matches no channel index
  // (LOAD_CH >= N_CH) simply hits nothing.
  for (genvar gi = 0; gi < N_CH; gi++) begin : g_ch
    assign load_hit[gi] = LOAD && (LOAD_CH == CH_W'(gi));

    servo_channel #(
      .PW_W      (PW_W),
      .MIN_PW    (MIN_PW),
      .MAX_PW    (MAX_PW),
      .CENTER_PW (CENTER_PW),
      .STEP      (STEP)
    ) u_ch (
      .clk            (CLK),
      .rst_n          (RST_N),
      .en             (EN),
      .frame_boundary (boundary),
      .frame_cnt      (frame_cnt_q),
      .dir            (DIR[2*gi +: 2]),
      .load           (load_hit[gi]),
      .load_val       (LOAD_VAL),
      .servo          (SERVO[gi]),
      .active_pw      (PULSE_WIDTH[gi*PW_W +: PW_W]),
      .at_min         (AT_MIN[gi]),
      .at_max         (AT_MAX[gi])
    );
  end

endmodule

// File: tb/tb_servo_pwm_sweep.sv
// Directed bench for servo_pwm_sweep with small timing parameters:
// CLK_DIV=2, FRAME_US=40 (80 CLK per frame), widths 5/15/25, STEP=10.
module tb_servo_pwm_sweep;

  logic        CLK;
  logic        RST_N;
  logic        EN;
  logic [3:0]  DIR;
  logic        LOAD;
  logic [0:0]  LOAD_CH;
  logic [15:0] LOAD_VAL;
  logic [1:0]  SERVO;
  logic [31:0] PULSE_WIDTH;
  logic [1:0]  AT_MIN;
  logic [1:0]  AT_MAX;
  logic        FRAME_START;

  int n_pass  = 0;
  int n_fail  = 0;
  int n_total = 0;

  servo_pwm_sweep #(
    .N_CH      (2),
    .PW_W      (16),
    .CLK_DIV   (2),
    .FRAME_US  (40),
    .MIN_PW    (5),
    .MAX_PW    (25),
    .CENTER_PW (15),
    .STEP      (10)
  ) dut (
    .CLK         (CLK),
    .RST_N       (RST_N),
    .EN          (EN),
    .DIR         (DIR),
    .LOAD        (LOAD),
    .LOAD_CH     (LOAD_CH),
    .LOAD_VAL    (LOAD_VAL),
    .SERVO       (SERVO),
    .PULSE_WIDTH (PULSE_WIDTH),
    .AT_MIN      (AT_MIN),
    .AT_MAX      (AT_MAX),
    .FRAME_START (FRAME_START)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) begin
      n_pass++;
    end else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic cyc();
    @(posedge CLK);
    #1;
  endtask

  // Bounded wait for FRAME_START; a fresh frame must announce itself 80 CLK later.
  task automatic wait_fs(input string tag);
    int n;
    n = 0;
    do begin
      cyc();
      n++;
    end while (!FRAME_START && n < 200);
    check(tag, 32'(n), 32'd80);
    $display("%s: FRAME_START after %0d cycles", tag, n);
  endtask

  // Runs one full frame starting just after a FRAME_START sample, optionally
  // pulsing LOAD at cycle ld_k (80 = the closing boundary cycle).
  task automatic run_frame(input string tag, input logic [3:0] dir,
                           input int ld_k, input int ld_ch, input int ld_val,
                           input int e0, input int e1);
    int hi0, hi1, fs_pos;
    logic [15:0] pw0, pw1;
    logic [1:0]  amin, amax;
    hi0 = 0; hi1 = 0; fs_pos = 0;
    pw0 = '0; pw1 = '0; amin = '0; amax = '0;
    DIR = dir;
    for (int k = 1; k <= 80; k++) begin
      LOAD     = (k == ld_k);
      LOAD_CH  = ld_ch[0];
      LOAD_VAL = 16'(ld_val);
      cyc();
      if (SERVO[0]) hi0++;
      if (SERVO[1]) hi1++;
      if (k == 1) begin
        pw0  = PULSE_WIDTH[15:0];
        pw1  = PULSE_WIDTH[31:16];
        amin = AT_MIN;
        amax = AT_MAX;
      end
      if (FRAME_START && fs_pos == 0) fs_pos = k;
    end
    LOAD = 1'b0;
    check({tag, " pw0"},   32'(pw0), 32'(e0));
    check({tag, " pw1"},   32'(pw1), 32'(e1));
    check({tag, " high0"}, 32'(hi0), 32'(2 * e0));
    check({tag, " high1"}, 32'(hi1), 32'(2 * e1));
    check({tag, " at_max"}, 32'(amax), 32'({e1 == 25, e0 == 25}));
    check({tag, " at_min"}, 32'(amin), 32'({e1 == 5, e0 == 5}));
    check({tag, " frame_start"}, 32'(fs_pos), 32'd80);
    $display("%s: dir=%b pw=%0d/%0d high=%0d/%0d fs@%0d", tag, dir, pw0, pw1, hi0, hi1, fs_pos);
  endtask

  // Frame table: DIR {ch1,ch0}, optional load, expected active widths.
  localparam int NF = 16;
  logic [3:0] t_dir [NF] = '{4'b0000, 4'b0001, 4'b0001, 4'b0001, 4'b0001,
                             4'b1000, 4'b1000, 4'b1000, 4'b1000,
                             4'b0000, 4'b0000, 4'b0000, 4'b0000,
                             4'b0001, 4'b0000, 4'b0000};
  int t_ldk [NF] = '{0, 0, 0, 0, 0, 0, 0, 0, 0, 10, 10, 10, 10, 80, 0, 0};
  int t_ldc [NF] = '{0, 0, 0, 0, 0, 0, 0, 0, 0,  0,  1,  0,  1,  0, 0, 0};
  int t_ldv [NF] = '{0, 0, 0, 0, 0, 0, 0, 0, 0, 12, 18, 100, 0, 10, 0, 0};
  int t_e0  [NF] = '{15, 15, 15, 25, 25, 25, 25, 25, 25, 25, 12, 12, 25, 25, 25, 10};
  int t_e1  [NF] = '{15, 15, 15, 15, 15, 15, 15,  5,  5,  5,  5, 18, 18,  5,  5,  5};

  initial begin
    int bad;
    RST_N = 1'b0; EN = 1'b0; DIR = 4'b0000;
    LOAD = 1'b0; LOAD_CH = 1'b0; LOAD_VAL = 16'd0;

    // Reset state.
    repeat (3) cyc();
    check("rst servo",       32'(SERVO),       32'd0);
    check("rst frame_start", 32'(FRAME_START), 32'd0);
    check("rst pulse_width", PULSE_WIDTH,      {16'd15, 16'd15});
    check("rst at_min",      32'(AT_MIN),      32'd0);
    check("rst at_max",      32'(AT_MAX),      32'd0);
    $display("reset: servo=%b pw=%0d/%0d", SERVO, PULSE_WIDTH[15:0], PULSE_WIDTH[31:16]);

    // Release, first (partial-count) frame, then the directed frame table:
    // hold, ch0 ramp up, ch1 ramp down, clamped loads, load on the boundary.
    RST_N = 1'b1; EN = 1'b1;
    wait_fs("first frame");
    for (int f = 0; f < NF; f++) begin
      run_frame($sformatf("f%0d", f), t_dir[f], t_ldk[f], t_ldc[f], t_ldv[f], t_e0[f], t_e1[f]);
    end

    // EN low mid-pulse: output drops next CLK, nothing runs, LOAD still lands.
    repeat (4) cyc();
    check("mid pulse servo", 32'(SERVO), 32'd3);
    EN = 1'b0; DIR = 4'b0101;
    cyc();
    check("en_off servo", 32'(SERVO), 32'd0);
    bad = 0;
    for (int i = 0; i < 150; i++) begin
      LOAD = (i == 50); LOAD_CH = 1'b1; LOAD_VAL = 16'd25;
      cyc();
      if (SERVO != 2'b00 || FRAME_START) bad++;
    end
    LOAD = 1'b0;
    check("en_off quiet", 32'(bad), 32'd0);
    $display("en low: %0d active samples", bad);
    EN = 1'b1;
    run_frame("en_back",  4'b0000, 0, 0, 0, 10, 5);
    run_frame("en_back2", 4'b0000, 0, 0, 0, 10, 25);

    // Asynchronous reset mid-frame with ch1 at full width.
    repeat (6) cyc();
    check("pre_rst servo", 32'(SERVO), 32'd3);
    RST_N = 1'b0;
    #1;
    check("async rst servo",       32'(SERVO),       32'd0);
    check("async rst pulse_width", PULSE_WIDTH,      {16'd15, 16'd15});
    check("async rst at_max",      32'(AT_MAX),      32'd0);
    check("async rst frame_start", 32'(FRAME_START), 32'd0);
    $display("async reset: servo=%b pw=%0d/%0d", SERVO, PULSE_WIDTH[15:0], PULSE_WIDTH[31:16]);
    repeat (3) cyc();
    RST_N = 1'b1;
    wait_fs("post_rst first frame");
    run_frame("post_rst", 4'b0000, 0, 0, 0, 15, 15);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
